arp_tx_sched: RTL and testbench

//  Sequences the ARP frame transmitter. Three request sources share it: replies from the ARP receiver,

---
 rtl/arp_pkg.sv | 9 +
 rtl/arp_garp_timer.sv | 27 ++
 rtl/arp_tx_sched.sv | 188 ++++++++++++++++++
 tb/tb_arp_tx_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP opcodes, broadcast MAC and scheduler types for the ARP sender, receiver and tx scheduler.
package arp_pkg;
  localparam logic [1:0]  ARP_OP_REQUEST = 2'd1;
  localparam logic [1:0]  ARP_OP_REPLY   = 2'd2;
  localparam logic [47:0] MAC_BCAST      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} sched_state_t;
  typedef enum logic [1:0] {SRC_RPLY, SRC_QUERY, SRC_GARP} src_t;
endpackage

// File: rtl/arp_garp_timer.sv
// Gratuitous-ARP period timer: 1-clk tick every GARP_PERIOD clocks (first tick GARP_PERIOD+1 after reset).
// No backpressure: the scheduler holds the tick as a pending flag; GARP_PERIOD=0 never ticks.
module arp_garp_timer #(
  parameter logic [31:0] GARP_PERIOD = 32'd125_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  logic [31:0] cnt_q, cnt_d;
  logic        en;

  assign en     = (GARP_PERIOD != 32'd0);
  assign o_tick = en && (cnt_q == 32'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = o_tick ? (GARP_PERIOD - 32'd1) : (cnt_q - 32'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= GARP_PERIOD;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/arp_tx_sched.sv
// ARP tx scheduler: fixed-priority (reply > query > GARP) grant over 1-deep slots; enable 3 clks after a request.
// Grants only when idle with i_ready high; fields held from grant to next grant; watchdog aborts stuck frames.
module arp_tx_sched #(
  parameter logic [31:0] GARP_PERIOD = 32'd125_000_000,
  parameter logic [7:0]  IFG_CLKS    = 8'd12,
  parameter logic [15:0] WDOG_CLKS   = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  input  logic        i_rply_req,
  input  logic [47:0] i_rply_mac,
  input  logic [31:0] i_rply_ip,
  input  logic        i_query_req,
  input  logic [31:0] i_query_ip,
  output logic        o_query_busy,
  output logic        o_enable,
  input  logic        i_ready,
  output logic [1:0]  o_operation,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [47:0] o_sha,
  output logic [31:0] o_spa,
  output logic [47:0] o_tha,
  output logic [31:0] o_tpa,
  output logic [7:0]  o_drop_cnt,
  output logic        o_wdog_err
);
  import arp_pkg::*;

  sched_state_t state_q, state_d;
  src_t         src;
  logic [15:0]  cnt_q, cnt_d;
  logic [16:0]  cnt_inc;
  logic         wdog_hit, gap_done, grant, garp_tick, query_acc;
  logic         rply_clr, query_clr, garp_clr;
  logic         rply_pend_q, rply_pend_d, query_pend_q, query_pend_d, garp_pend_q, garp_pend_d;
  logic [47:0]  rply_mac_q;
  logic [31:0]  rply_ip_q, query_ip_q;
  logic [7:0]   drop_q, drop_d;
  logic         wdog_q, wdog_d;
  logic [1:0]   op_q;
  logic [47:0]  dst_q, sha_q, tha_q;
  logic [31:0]  spa_q, tpa_q;

  arp_garp_timer #(.GARP_PERIOD(GARP_PERIOD)) u_garp_timer (
    .clk    (clk),
    .rst    (rst),
    .o_tick (garp_tick)
  );

  assign grant = (state_q == IDLE) && i_ready && (rply_pend_q || query_pend_q || garp_pend_q);

  always_comb begin
    src = SRC_GARP;
    if (rply_pend_q)       src = SRC_RPLY;
    else if (query_pend_q) src = SRC_QUERY;
  end

  assign rply_clr  = grant && (src == SRC_RPLY);
  assign query_clr = grant && (src == SRC_QUERY);
  assign garp_clr  = grant && (src == SRC_GARP);

  // A set on the same clock as the slot's grant wins, so that request is kept for the next frame.
  always_comb begin
    rply_pend_d  = rply_pend_q;
    query_pend_d = query_pend_q;
    garp_pend_d  = garp_pend_q;
    drop_d       = drop_q;
    query_acc    = i_query_req && (!query_pend_q || query_clr);
    if (rply_clr)  rply_pend_d  = 1'b0;
    if (query_clr) query_pend_d = 1'b0;
    if (garp_clr)  garp_pend_d  = 1'b0;
    if (i_rply_req) rply_pend_d = 1'b1;
    if (query_acc)  query_pend_d = 1'b1;
    if (garp_tick)  garp_pend_d  = 1'b1;
    if (i_rply_req && rply_pend_q && !rply_clr && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  assign cnt_inc  = {1'b0, cnt_q} + 17'd1;
  assign wdog_hit = (cnt_inc >= {1'b0, WDOG_CLKS});
  assign gap_done = (cnt_inc >= {9'd0, IFG_CLKS});

  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    o_enable = 1'b0;
    case (state_q)
      IDLE: if (grant) state_d = LOAD;
      LOAD: state_d = START;
      START: begin
        o_enable = 1'b1;
        if (!i_ready) state_d = WAIT_DONE;
        else if (wdog_hit) begin
          state_d = GAP;
          wdog_d  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (i_ready) state_d = GAP;
        else if (wdog_hit) begin
          state_d = GAP;
          wdog_d  = 1'b1;
        end
      end
      GAP: if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // One counter serves watchdog and inter-frame gap; it restarts on every state change.
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = 16'd0;
    else if (state_q inside {START, WAIT_DONE, GAP}) cnt_d = cnt_inc[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      rply_pend_q  <= 1'b0;
      query_pend_q <= 1'b0;
      garp_pend_q  <= 1'b0;
      rply_mac_q   <= 48'd0;
      rply_ip_q    <= 32'd0;
      query_ip_q   <= 32'd0;
      drop_q       <= 8'd0;
      wdog_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rply_pend_q  <= rply_pend_d;
      query_pend_q <= query_pend_d;
      garp_pend_q  <= garp_pend_d;
      drop_q       <= drop_d;
      wdog_q       <= wdog_d;
      if (i_rply_req) begin
        rply_mac_q <= i_rply_mac;
        rply_ip_q  <= i_rply_ip;
      end
      if (query_acc) query_ip_q <= i_query_ip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 2'd0;
      dst_q <= 48'd0;
      sha_q <= 48'd0;
      spa_q <= 32'd0;
      tha_q <= 48'd0;
      tpa_q <= 32'd0;
    end else if (grant) begin
      sha_q <= i_my_mac;
      spa_q <= i_my_ip;
      case (src)
        SRC_RPLY: begin
          op_q  <= ARP_OP_REPLY;
          dst_q <= rply_mac_q;
          tha_q <= rply_mac_q;
          tpa_q <= rply_ip_q;
        end
        SRC_QUERY: begin
          op_q  <= ARP_OP_REQUEST;
          dst_q <= MAC_BCAST;
          tha_q <= 48'd0;
          tpa_q <= query_ip_q;
        end
        default: begin
          op_q  <= ARP_OP_REQUEST;
          dst_q <= MAC_BCAST;
          tha_q <= 48'd0;
          tpa_q <= i_my_ip;
        end
      endcase
    end
  end

  assign o_query_busy = query_pend_q;
  assign o_operation  = op_q;
  assign o_dst_mac    = dst_q;
  assign o_src_mac    = sha_q;
  assign o_sha        = sha_q;
  assign o_spa        = spa_q;
  assign o_tha        = tha_q;
  assign o_tpa        = tpa_q;
  assign o_drop_cnt   = drop_q;
  assign o_wdog_err   = wdog_q;
endmodule

// File: tb/tb_arp_tx_sched.sv
// Bench for arp_tx_sched: one DUT with GARP disabled for reply/query traffic, one with GARP_PERIOD=100 alone.
module tb_arp_tx_sched;
  localparam logic [7:0]  IFG    = 8'd12;
  localparam logic [15:0] WDOG   = 16'd400;
  localparam logic [47:0] MY_MAC = 48'h02AA_BBCC_DD01;
  localparam logic [31:0] MY_IP  = 32'hC0A8_0101;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

  typedef struct packed {
    logic [1:0]  op;
    logic [47:0] dst;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  typedef struct {
    logic        is_query;
    logic [47:0] mac;
    logic [31:0] ip;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        i_rply_req = 1'b0, i_query_req = 1'b0;
  logic [47:0] i_rply_mac = '0;
  logic [31:0] i_rply_ip = '0, i_query_ip = '0;
  logic        rdy0 = 1'b1, rdy1 = 1'b1;
  logic        en0, en1, busy0, wdog0;
  logic [1:0]  op0, g_op;
  logic [47:0] dst0, src0, sha0, tha0, g_dst, g_src, g_sha, g_tha;
  logic [31:0] spa0, tpa0, g_spa, g_tpa;
  logic [7:0]  drop0, g_drop;
  logic        g_busy, g_wdog;

  int n_vec = 0, n_err = 0, cyc = 0;
  frame_t sb[$];
  vec_t   vecs[4];

  arp_tx_sched #(.GARP_PERIOD(32'd0), .IFG_CLKS(IFG), .WDOG_CLKS(WDOG)) dut (
    .clk(clk), .rst(rst), .i_my_mac(MY_MAC), .i_my_ip(MY_IP),
    .i_rply_req(i_rply_req), .i_rply_mac(i_rply_mac), .i_rply_ip(i_rply_ip),
    .i_query_req(i_query_req), .i_query_ip(i_query_ip), .o_query_busy(busy0),
    .o_enable(en0), .i_ready(rdy0), .o_operation(op0), .o_dst_mac(dst0), .o_src_mac(src0),
    .o_sha(sha0), .o_spa(spa0), .o_tha(tha0), .o_tpa(tpa0), .o_drop_cnt(drop0), .o_wdog_err(wdog0)
  );

  arp_tx_sched #(.GARP_PERIOD(32'd100), .IFG_CLKS(IFG), .WDOG_CLKS(WDOG)) dutg (
    .clk(clk), .rst(rst), .i_my_mac(MY_MAC), .i_my_ip(MY_IP),
    .i_rply_req(1'b0), .i_rply_mac(48'd0), .i_rply_ip(32'd0),
    .i_query_req(1'b0), .i_query_ip(32'd0), .o_query_busy(g_busy),
    .o_enable(en1), .i_ready(rdy1), .o_operation(g_op), .o_dst_mac(g_dst), .o_src_mac(g_src),
    .o_sha(g_sha), .o_spa(g_spa), .o_tha(g_tha), .o_tpa(g_tpa), .o_drop_cnt(g_drop), .o_wdog_err(g_wdog)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t rply_exp(input logic [47:0] mac, input logic [31:0] ip);
    return '{op: 2'd2, dst: mac, tha: mac, tpa: ip};
  endfunction

  function automatic frame_t query_exp(input logic [31:0] ip);
    return '{op: 2'd1, dst: BCAST, tha: 48'd0, tpa: ip};
  endfunction

  function automatic vec_t mkv(input logic q, input logic [47:0] mac, input logic [31:0] ip,
                               input logic [1:0] op, input logic [47:0] dst,
                               input logic [47:0] tha, input logic [31:0] tpa);
    vec_t v;
    v.is_query = q; v.mac = mac; v.ip = ip;
    v.exp = '{op: op, dst: dst, tha: tha, tpa: tpa};
    return v;
  endfunction

  // Transmitter model: ready drops 1 clk after enable, returns 80 clks after enable is low.
  bit stuck = 1'b0, mb0 = 1'b0, mb1 = 1'b0;
  int mc0 = 0, mc1 = 0;
  always @(negedge clk) begin
    if (rst) begin
      rdy0 = 1'b1; mb0 = 1'b0; rdy1 = 1'b1; mb1 = 1'b0;
    end else begin
      if (!mb0) begin
        if (en0 && !stuck) begin rdy0 = 1'b0; mb0 = 1'b1; mc0 = 0; end
      end else if (!en0) begin
        mc0++;
        if (mc0 >= 80) begin rdy0 = 1'b1; mb0 = 1'b0; end
      end
      if (!mb1) begin
        if (en1) begin rdy1 = 1'b0; mb1 = 1'b1; mc1 = 0; end
      end else if (!en1) begin
        mc1++;
        if (mc1 >= 80) begin rdy1 = 1'b1; mb1 = 1'b0; end
      end
    end
  end

  int started0 = 0, done0 = 0, en_cyc = 0, t_rise = 0, t_end = 0, gap_last = 0, t_req = 0;
  bit in_frame = 1'b0, unstable = 1'b0;
  logic [257:0] snap;
  frame_t e;
  always @(posedge clk) begin
    #1;
    if (rst) in_frame = 1'b0;
    else begin
      if (en0 && !in_frame) begin
        in_frame = 1'b1; started0++; t_rise = cyc; gap_last = cyc - t_end;
        en_cyc = 0; unstable = 1'b0;
        snap = {op0, dst0, src0, sha0, spa0, tha0, tpa0};
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_frame: op %0h tpa %0h with empty scoreboard", op0, tpa0);
        end else begin
          e = sb.pop_front();
          chk("op", 64'(op0), 64'(e.op));
          chk("dst_mac", 64'(dst0), 64'(e.dst));
          chk("tha", 64'(tha0), 64'(e.tha));
          chk("tpa", 64'(tpa0), 64'(e.tpa));
          chk("src_mac", 64'(src0), 64'(MY_MAC));
          chk("sha", 64'(sha0), 64'(MY_MAC));
          chk("spa", 64'(spa0), 64'(MY_IP));
        end
      end
      if (in_frame) begin
        if (en0) en_cyc++;
        if ({op0, dst0, src0, sha0, spa0, tha0, tpa0} != snap) unstable = 1'b1;
        if (!en0 && rdy0) begin
          in_frame = 1'b0; done0++; t_end = cyc;
          chk("fields_stable", 64'(unstable), 64'd0);
          chk("enable_cycles", 64'(en_cyc), stuck ? 64'(WDOG) : 64'd1);
        end
      end
    end
  end

  int g_started = 0;
  bit g_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) g_prev = 1'b0;
    else begin
      if (en1 && !g_prev) begin
        g_started++;
        chk("garp_op", 64'(g_op), 64'd1);
        chk("garp_dst", 64'(g_dst), 64'(BCAST));
        chk("garp_tha", 64'(g_tha), 64'd0);
        chk("garp_tpa", 64'(g_tpa), 64'(MY_IP));
        chk("garp_src_sha_spa", {g_src == MY_MAC, g_sha == MY_MAC, g_spa == MY_IP}, 64'd7);
        chk("garp_idle_flags", {g_busy, g_wdog, g_drop}, 64'd0);
      end
      g_prev = en1;
    end
  end

  task automatic pulse(input logic r, input logic q, input logic [47:0] mac,
                       input logic [31:0] ip, input logic [31:0] qip);
    i_rply_req = r; i_rply_mac = mac; i_rply_ip = ip;
    i_query_req = q; i_query_ip = qip;
    t_req = cyc;
    @(negedge clk);
    i_rply_req = 1'b0; i_query_req = 1'b0;
  endtask

  task automatic wait_started(input int tgt, input int budget);
    int k = 0;
    while (started0 < tgt && k < budget) begin @(negedge clk); k++; end
    chk("start_timeout", 64'(started0 >= tgt), 64'd1);
  endtask

  task automatic wait_done(input int tgt, input int budget);
    int k = 0;
    while (done0 < tgt && k < budget) begin @(negedge clk); k++; end
    chk("done_timeout", 64'(done0 >= tgt), 64'd1);
  endtask

  initial begin
    int tgt, s, gs, k;
    logic [47:0] lmac;
    logic [31:0] lip;
    vecs[0] = mkv(1'b0, 48'h0200_0000_0007, 32'hC0A8_0107, 2'd2, 48'h0200_0000_0007, 48'h0200_0000_0007, 32'hC0A8_0107);
    vecs[1] = mkv(1'b1, 48'd0, 32'hC0A8_0155, 2'd1, BCAST, 48'd0, 32'hC0A8_0155);
    vecs[2] = mkv(1'b0, 48'h0A1B_2C3D_4E5F, 32'h0A00_0001, 2'd2, 48'h0A1B_2C3D_4E5F, 48'h0A1B_2C3D_4E5F, 32'h0A00_0001);
    vecs[3] = mkv(1'b1, 48'd0, 32'h0A00_00FE, 2'd1, BCAST, 48'd0, 32'h0A00_00FE);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enable", 64'(en0), 64'd0);
    chk("rst_fields", {op0, tpa0, spa0}, 64'd0);
    chk("rst_dst_tha", 64'(dst0 | tha0 | sha0 | src0), 64'd0);
    chk("rst_flags", {busy0, wdog0, drop0}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      tgt = done0 + 1;
      sb.push_back(vecs[i].exp);
      pulse(!vecs[i].is_query, vecs[i].is_query, vecs[i].mac, vecs[i].ip, vecs[i].ip);
      wait_done(tgt, 400);
      chk("latency", 64'(t_rise - t_req), 64'd3);
      repeat (20) @(negedge clk);
    end

    // Reply and query on the same clock: reply first, query after the inter-frame gap.
    tgt = done0 + 2; s = started0;
    sb.push_back(rply_exp(48'h0200_0000_0021, 32'hC0A8_0121));
    sb.push_back(query_exp(32'hC0A8_0122));
    pulse(1'b1, 1'b1, 48'h0200_0000_0021, 32'hC0A8_0121, 32'hC0A8_0122);
    wait_started(s + 1, 50);
    chk("query_busy_pending", 64'(busy0), 64'd1);
    wait_started(s + 2, 400);
    chk("query_busy_at_grant", 64'(busy0), 64'd0);
    chk("ifg_gap", 64'(gap_last), 64'(IFG) + 64'd2);
    wait_done(tgt, 400);
    repeat (20) @(negedge clk);

    // Three replies while a query frame is in flight: last one wins, two drops.
    tgt = done0 + 2; s = started0;
    sb.push_back(query_exp(32'hC0A8_0130));
    pulse(1'b0, 1'b1, 48'd0, 32'd0, 32'hC0A8_0130);
    wait_started(s + 1, 50);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 48'h0200_0000_0031, 32'hC0A8_0131, 32'd0);
    pulse(1'b1, 1'b0, 48'h0200_0000_0032, 32'hC0A8_0132, 32'd0);
    sb.push_back(rply_exp(48'h0200_0000_0033, 32'hC0A8_0133));
    pulse(1'b1, 1'b0, 48'h0200_0000_0033, 32'hC0A8_0133, 32'd0);
    wait_done(tgt, 600);
    chk("drop_cnt_after_3", 64'(drop0), 64'd2);
    repeat (20) @(negedge clk);

    s = started0; gs = g_started;
    repeat (1000) @(negedge clk);
    chk("garp_frames_1000clk", 64'(g_started - gs), 64'd10);
    chk("no_garp_when_disabled", 64'(started0 - s), 64'd0);

    // Stuck transmitter: watchdog abort, drop counter saturation, then recovery.
    stuck = 1'b1; tgt = done0 + 2; s = started0;
    sb.push_back(rply_exp(48'h0200_0000_0040, 32'hC0A8_0140));
    pulse(1'b1, 1'b0, 48'h0200_0000_0040, 32'hC0A8_0140, 32'd0);
    wait_started(s + 1, 50);
    chk("wdog_clear_before", 64'(wdog0), 64'd0);
    lmac = 48'd0; lip = 32'd0;
    for (int j = 0; j < 300; j++) begin
      lmac = 48'h0200_0000_1000 + 48'(j);
      lip  = 32'h0A00_1000 + 32'(j);
      i_rply_req = 1'b1; i_rply_mac = lmac; i_rply_ip = lip;
      @(negedge clk);
    end
    i_rply_req = 1'b0;
    sb.push_back(rply_exp(lmac, lip));
    chk("drop_saturated", 64'(drop0), 64'hFF);
    k = 0;
    while (en0 && k < 300) begin @(negedge clk); k++; end
    chk("enable_after_abort", 64'(en0), 64'd0);
    chk("wdog_err", 64'(wdog0), 64'd1);
    stuck = 1'b0;
    wait_done(tgt, 600);
    chk("wdog_sticky", 64'(wdog0), 64'd1);
    repeat (20) @(negedge clk);

    // Reset in WAIT_DONE with a query still queued.
    s = started0;
    sb.push_back(rply_exp(48'h0200_0000_0050, 32'hC0A8_0150));
    sb.push_back(query_exp(32'hC0A8_0151));
    pulse(1'b1, 1'b1, 48'h0200_0000_0050, 32'hC0A8_0150, 32'hC0A8_0151);
    wait_started(s + 1, 50);
    repeat (5) @(negedge clk);
    chk("busy_before_rst", 64'(busy0), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_enable", 64'(en0), 64'd0);
    chk("midrst_flags", {busy0, wdog0, drop0}, 64'd0);
    chk("midrst_fields", {op0, tpa0}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    s = started0;
    repeat (300) @(negedge clk);
    chk("no_stale_frame", 64'(started0 - s), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
